// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wport_arbiter : shares the register-file write port between WB and
// a small FIFO of deferred L1 miss-return loads.   Revision 1.0
// ============================================================================
module regfile_wport_arbiter #(
  parameter int bit_size     = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_addr,
  input  logic [bit_size-1:0]       wb_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [4:0]                ld_addr,
  input  logic [bit_size-1:0]       ld_data,
  input  logic [4:0]                rs_addr_1,
  input  logic [4:0]                rs_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2,
  output logic                      starve_stall,
  output logic                      RegWrite,
  output logic [4:0]                Write_addr,
  output logic [bit_size-1:0]       Write_data,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    kill_q, kill_d;
  logic [4:0]          addr_q [DEPTH];
  logic [4:0]          addr_d [DEPTH];
  logic [bit_size-1:0] data_q [DEPTH];
  logic [bit_size-1:0] data_d [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                stall_q, stall_d;
  logic                regwrite_q, regwrite_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [bit_size-1:0] wdata_q, wdata_d;

  logic w_wb_win;
  logic w_push;
  logic w_pop;
  logic w_hit_1;
  logic w_hit_2;

  assign ld_ready = rst && (count_q != C_FULL);
  assign w_wb_win = wb_valid && (wb_addr != 5'd0);
  // A handshake to r0 completes but never occupies a slot.
  assign w_push   = ld_valid && ld_ready && (ld_addr != 5'd0);
  assign w_pop    = !w_wb_win && (count_q != '0);

  always_comb begin
    w_hit_1 = 1'b0;
    w_hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i] && (addr_q[i] == rs_addr_1)) w_hit_1 = 1'b1;
      if (valid_q[i] && !kill_q[i] && (addr_q[i] == rs_addr_2)) w_hit_2 = 1'b1;
    end
  end

  assign hazard_1 = (rs_addr_1 != 5'd0) &&
                    (w_hit_1 || (regwrite_q && (waddr_q == rs_addr_1)));
  assign hazard_2 = (rs_addr_2 != 5'd0) &&
                    (w_hit_2 || (regwrite_q && (waddr_q == rs_addr_2)));

  always_comb begin
    valid_d    = valid_q;
    kill_d     = kill_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;

    if (w_wb_win) begin
      regwrite_d = 1'b1;
      waddr_d    = wb_addr;
      wdata_d    = wb_data;
      // Older queued loads to the same register would overwrite newer WB data.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (addr_q[i] == wb_addr)) kill_d[i] = 1'b1;
      end
    end else if (w_pop) begin
      regwrite_d = !kill_q[rd_ptr_q];
      if (!kill_q[rd_ptr_q]) begin
        waddr_d = addr_q[rd_ptr_q];
        wdata_d = data_q[rd_ptr_q];
      end
      valid_d[rd_ptr_q] = 1'b0;
      kill_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end

    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      kill_d[wr_ptr_q]  = 1'b0;
      addr_d[wr_ptr_q]  = ld_addr;
      data_d[wr_ptr_q]  = ld_data;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(w_push) - CW'(w_pop);

    if (w_pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (w_wb_win && (starve_q != C_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = (starve_d >= C_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      kill_q     <= '0;
      addr_q     <= '{default: '0};
      data_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      kill_q     <= kill_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite     = regwrite_q;
  assign Write_addr   = waddr_q;
  assign Write_data   = wdata_q;
  assign fifo_count   = count_q;
  assign starve_stall = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wport_arbiter : directed checks of the write-port arbiter.
// Revision 1.0
// ============================================================================
module tb_regfile_wport_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  rs_addr_1;
  logic [4:0]  rs_addr_2;
  logic        hazard_1;
  logic        hazard_2;
  logic        starve_stall;
  logic        RegWrite;
  logic [4:0]  Write_addr;
  logic [31:0] Write_data;
  logic [1:0]  fifo_count;

  int total;
  int bad;

  regfile_wport_arbiter #(
    .bit_size(32),
    .DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .rs_addr_1(rs_addr_1),
    .rs_addr_2(rs_addr_2),
    .hazard_1(hazard_1),
    .hazard_2(hazard_2),
    .starve_stall(starve_stall),
    .RegWrite(RegWrite),
    .Write_addr(Write_addr),
    .Write_data(Write_data),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    wb_valid  = 1'b1;
    wb_addr   = 5'd6;
    wb_data   = 32'h66;
    ld_valid  = 1'b1;
    ld_addr   = 5'd7;
    ld_data   = 32'h77;
    rs_addr_1 = 5'd0;
    rs_addr_2 = 5'd0;

    // Reset with requests active
    tick(); tick(); tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_waddr", Write_addr, 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_stall", starve_stall, 0);

    rst = 1'b1; wb_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("rel_ld_ready", ld_ready, 1);
    chk("rel_regwrite", RegWrite, 0);
    chk("rel_count", fifo_count, 0);

    // Single WB write
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs_addr_1 = 5'd5;
    tick();
    chk("wb_regwrite", RegWrite, 1);
    chk("wb_waddr", Write_addr, 5);
    chk("wb_wdata", Write_data, 32'hDEADBEEF);
    chk("wb_hazard", hazard_1, 1);
    wb_valid = 1'b0;
    tick();
    chk("wb_done_regwrite", RegWrite, 0);
    chk("wb_hold_waddr", Write_addr, 5);
    chk("wb_hazard_clear", hazard_1, 0);

    // Fill FIFO under constant WB traffic
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h11;
    tick();
    chk("fill1_count", fifo_count, 1);
    chk("fill1_ready", ld_ready, 1);
    ld_addr = 5'd8; ld_data = 32'h22;
    tick();
    rs_addr_1 = 5'd8; rs_addr_2 = 5'd7;
    #1;
    chk("fill2_count", fifo_count, 2);
    chk("fill2_ready", ld_ready, 0);
    chk("fill2_haz1", hazard_1, 1);
    chk("fill2_haz2", hazard_2, 1);
    ld_addr = 5'd10; ld_data = 32'h99;
    tick();
    chk("refuse_count", fifo_count, 2);
    chk("refuse_regwrite", RegWrite, 1);
    chk("refuse_waddr", Write_addr, 3);
    wb_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("drain1_regwrite", RegWrite, 1);
    chk("drain1_waddr", Write_addr, 7);
    chk("drain1_wdata", Write_data, 32'h11);
    chk("drain1_count", fifo_count, 1);
    tick();
    chk("drain2_regwrite", RegWrite, 1);
    chk("drain2_waddr", Write_addr, 8);
    chk("drain2_wdata", Write_data, 32'h22);
    chk("drain2_count", fifo_count, 0);
    chk("drain2_haz1", hazard_1, 1);
    tick();
    chk("drain_idle_regwrite", RegWrite, 0);
    chk("drain_idle_haz1", hazard_1, 0);
    chk("drain_idle_ready", ld_ready, 1);

    // WAW kill of a queued load
    rs_addr_1 = 5'd9; rs_addr_2 = 5'd0;
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
    chk("waw_count", fifo_count, 1);
    chk("waw_haz_queued", hazard_1, 1);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD;
    tick();
    chk("waw_wb_regwrite", RegWrite, 1);
    chk("waw_wb_haz", hazard_1, 1);
    chk("waw_wb_count", fifo_count, 1);
    wb_valid = 1'b0;
    tick();
    chk("waw_pop_regwrite", RegWrite, 0);
    chk("waw_pop_count", fifo_count, 0);
    chk("waw_pop_haz", hazard_1, 0);
    chk("waw_keep_waddr", Write_addr, 9);
    chk("waw_keep_wdata", Write_data, 32'hABCD);

    // Starvation
    rs_addr_1 = 5'd0;
    ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h1234;
    tick();
    ld_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    tick(); tick(); tick();
    chk("starve3_stall", starve_stall, 0);
    tick();
    chk("starve4_stall", starve_stall, 1);
    tick(); tick();
    chk("starve6_stall", starve_stall, 1);
    chk("starve6_count", fifo_count, 1);
    wb_valid = 1'b0;
    tick();
    chk("starve_pop_stall", starve_stall, 0);
    chk("starve_pop_waddr", Write_addr, 12);
    chk("starve_pop_wdata", Write_data, 32'h1234);
    chk("starve_pop_count", fifo_count, 0);

    // Simultaneous push and pop across pointer wrap
    ld_valid = 1'b1; ld_addr = 5'd20; ld_data = 32'h2020;
    tick();
    ld_addr = 5'd21; ld_data = 32'h2121;
    tick();
    chk("pp_count", fifo_count, 1);
    chk("pp_waddr", Write_addr, 20);
    chk("pp_wdata", Write_data, 32'h2020);
    ld_valid = 1'b0;
    tick();
    chk("pp_pop2_waddr", Write_addr, 21);
    chk("pp_pop2_count", fifo_count, 0);

    // Register 0 on both sources
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h5555;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h6666;
    rs_addr_1 = 5'd0;
    #1;
    chk("r0_ready", ld_ready, 1);
    tick();
    chk("r0_count", fifo_count, 0);
    chk("r0_regwrite", RegWrite, 0);
    chk("r0_hazard", hazard_1, 0);
    tick();
    chk("r0_regwrite2", RegWrite, 0);
    chk("r0_waddr_hold", Write_addr, 21);

    // Reset while an entry is queued
    wb_valid = 1'b0;
    ld_addr = 5'd15; ld_data = 32'hF0F0;
    tick();
    ld_valid = 1'b0;
    chk("midrst_pre_count", fifo_count, 1);
    rst = 1'b0;
    tick();
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ready", ld_ready, 0);
    chk("midrst_waddr", Write_addr, 0);
    rst = 1'b1;
    tick();
    chk("midrst_post_regwrite", RegWrite, 0);
    chk("midrst_post_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and the L1 data-cache miss-return path.
- WB writes have absolute priority. Deferred load returns are buffered in a small FIFO and drained into idle write cycles.
- Drives the register file's write port one cycle after arbitration.
- Flags decode-stage read hazards against pending writes, kills stale queued writes (WAW), and requests a pipeline bubble when the load queue starves.

Parameters:
- bit_size, 32, register data width
- DEPTH, 2, load-return FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive WB-won cycles with a non-empty FIFO before starve_stall asserts

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- wb_valid  in  1  pipeline WB write request; cannot be back-pressured
- wb_addr  in  5  WB destination register
- wb_data  in  bit_size  WB write data
- ld_valid  in  1  miss-return load write offered
- ld_ready  out  1  FIFO can accept a load return
- ld_addr  in  5  load destination register
- ld_data  in  bit_size  load data
- rs_addr_1  in  5  decode source register 1
- rs_addr_2  in  5  decode source register 2
- hazard_1  out  1  rs_addr_1 has a pending write
- hazard_2  out  1  rs_addr_2 has a pending write
- starve_stall  out  1  request that the pipeline present wb_valid=0 next cycle
- RegWrite  out  1  register-file write enable (registered)
- Write_addr  out  5  register-file write address (registered)
- Write_data  out  bit_size  register-file write data (registered)
- fifo_count  out  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (rst==0 at posedge):
  - RegWrite=0, Write_addr=0, Write_data=0.
  - FIFO empty, fifo_count=0, all kill bits cleared, starvation counter=0, starve_stall=0.
  - Queued entries are discarded, including on reset mid-operation.
  - ld_ready=0 while rst==0; ld_ready=1 on the first cycle after release.
- ld_ready = rst && (fifo_count != DEPTH), computed from registered count only.
  - A full FIFO does not accept a push even if a pop occurs in the same cycle.
- Push when ld_valid && ld_ready.
  - ld_addr==0: handshake completes, nothing is stored.
- Arbitration each cycle, evaluated on state before the edge:
  - wb_valid && wb_addr!=0: WB wins. Next cycle RegWrite=1, Write_addr=wb_addr, Write_data=wb_data. The FIFO is not popped.
  - wb_valid && wb_addr==0: treated as no WB request.
  - Otherwise, FIFO non-empty: pop the head.
    - Head not killed: next cycle RegWrite=1 with the head's addr/data.
    - Head killed: RegWrite=0 that cycle; the slot is still consumed.
  - Otherwise: RegWrite=0. Write_addr/Write_data hold their previous values.
- Latency:
  - WB request to register-file write: 1 cycle.
  - Accepted load to write: at least 2 cycles (push, then pop when the port is idle).
- Simultaneous push and pop (FIFO not full): both happen; count unchanged.
  - With an empty FIFO, an incoming load is pushed and cannot pop in the same cycle.
- Pointers wrap modulo DEPTH.
- WAW kill:
  - When WB wins with wb_addr==A, every valid FIFO entry with addr A gets its kill bit set.
  - A load pushed in the same cycle to addr A is not killed.
- Hazards (combinational from registered state only):
  - hazard_n = (rs_addr_n != 0) && rs_addr_n matches a valid, non-killed FIFO entry, or (RegWrite && Write_addr==rs_addr_n).
  - A load accepted this cycle becomes visible next cycle.
- Starvation:
  - Counter increments each cycle WB wins while fifo_count != 0.
  - Counter clears when a pop occurs or the FIFO is empty.
  - starve_stall = (counter >= STARVE_LIMIT), registered.
  - starve_stall stays asserted until the pop occurs.
- Out-of-range conditions: push when not ready and wb_addr==0 are ignored silently; no error output.

Test Plan:
- Reset held 3 cycles with ld_valid=1, wb_valid=1 -> RegWrite=0, ld_ready=0, fifo_count=0. After release, ld_ready=1.
- wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF for 1 cycle -> next cycle RegWrite=1, Write_addr=5, Write_data=0xDEADBEEF. Following cycle RegWrite=0.
- Push loads (7,0x11), (8,0x22) with wb_valid=1 to addr 3 held -> ld_ready=0 at count 2; a third load is refused; hazard_1=1 for rs_addr_1=8. Drop wb_valid -> writes r7=0x11, then r8=0x22, in order, on consecutive cycles.
- Queue load to r9, then WB wins with wb_addr=9 -> entry killed; hazard on r9 clears once WB's RegWrite ends. Pop yields RegWrite=0; r9 keeps the WB value.
- FIFO count 1, wb_valid=1 to r4 for 6 cycles -> starve_stall=1 after 4 WB-won cycles. Drop wb_valid -> pop, then starve_stall=0 next cycle.
- Load with ld_addr=0, and wb_addr=0 -> handshake completes, fifo_count unchanged, RegWrite stays 0.
